// File: rtl/modadd_sched_pkg.sv
// Shared constants and types for the modular-adder scheduler.
// Holds the field modulus, the FSM encoding and the timeout counter sizing.
package modadd_pkg;

  localparam int MODADD_W = 256;
  // 2^255 - 19
  localparam logic [255:0] MODADD_P = {4'h7, {244{1'b1}}, 8'hed};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Counter holds 0..timeout-1; never narrower than one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/modadd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after i_ptr.
// The pointer itself lives in the scheduler.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int k;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(i_ptr) + i) % N;
      if (!o_any && i_req[k]) begin
        o_any      = 1'b1;
        o_grant[k] = 1'b1;
        o_idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/modadd_sched.sv
// Shares one modular adder core between N_REQ requesters, one operation at a time,
// with operand range checking, core start sequencing and a hung-core timeout.
//
// state | meaning
// IDLE  | arbitrate and accept one operand pair
// LOAD  | operands on core_a/core_b, core held in reset one cycle
// RUN   | core released, wait for core_done or timeout
// RESP  | tagged result presented until resp_ready
module modadd_sched
  import modadd_pkg::*;
#(
  parameter int           W       = MODADD_W,
  parameter int           N_REQ   = 4,
  parameter logic [W-1:0] P       = W'(MODADD_P),
  parameter int           TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [W-1:0]             resp_data,
  output logic                     resp_err,
  output logic [W-1:0]             core_a,
  output logic [W-1:0]             core_b,
  output logic                     core_rst,
  input  logic [W-1:0]             core_out,
  input  logic                     core_done
);

  localparam int            IW       = $clog2(N_REQ);
  localparam int            CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_id;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_data;
  logic          r_err;
  logic          r_resp_valid;
  logic          r_core_rst;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic             w_accept;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic             w_range_bad;
  logic [IW-1:0]    w_ptr_next;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_accept  = (r_state == IDLE) && w_any;
  // Masked by rst so the grant drops the instant reset is applied.
  assign req_ready = ((r_state == IDLE) && !rst) ? w_grant : '0;

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[i*W +: W];
        w_sel_b = req_b[i*W +: W];
      end
    end
  end

  assign w_range_bad = (w_sel_a >= P) || (w_sel_b >= P);
  assign w_ptr_next  = (r_id == IW'(N_REQ - 1)) ? '0 : r_id + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_core_rst   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            r_id <= w_idx;
            if (w_range_bad) begin
              r_err        <= 1'b1;
              r_data       <= '0;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          r_cnt      <= '0;
          r_core_rst <= 1'b0;
          r_state    <= RUN;
        end
        RUN: begin
          if (core_done) begin
            r_data       <= core_out;
            r_err        <= 1'b0;
            r_core_rst   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_data       <= '0;
            r_err        <= 1'b1;
            r_core_rst   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_ptr        <= w_ptr_next;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_id;
  assign resp_data  = r_data;
  assign resp_err   = r_err;
  assign core_a     = r_a;
  assign core_b     = r_b;
  assign core_rst   = r_core_rst;

endmodule

// File: doc/modadd_sched.md
# modadd_sched

Round-robin scheduler that shares one `simple_modular_adder` core (mod P = 2^255−19) between N_REQ requesters. It accepts one operand pair at a time and range-checks both operands against P. It sequences the core through its reset-release protocol, guards against a hung core with a timeout, and returns a tagged result. The block sits between the ECC point-arithmetic controllers and the single adder instance.

## Interface
Parameters:
- `W`, 256: operand/result width.
- `N_REQ`, 4: number of requesters. Must be at least 2.
- `P`, 256'h7fff…ffed (2^255−19): field modulus.
- `TIMEOUT`, 64: maximum number of RUN cycles to wait for `core_done`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req_valid`, in, N_REQ: request valid, one bit per requester.
- `req_ready`, out, N_REQ: grant/accept, one-hot or zero.
- `req_a`, in, N_REQ·W: packed operand A. Requester i uses slice [i·W +: W].
- `req_b`, in, N_REQ·W: packed operand B.
- `resp_valid`, out, 1: response valid.
- `resp_ready`, in, 1: response accepted.
- `resp_id`, out, $clog2(N_REQ): index of the requester being answered.
- `resp_data`, out, W: (a+b) mod P, or 0 on error.
- `resp_err`, out, 1: 1 means an operand was ≥ P or the core timed out.
- `core_a`, out, W: operand A to the core.
- `core_b`, out, W: operand B to the core.
- `core_rst`, out, 1: core reset/start. High holds the core idle; low lets it run.
- `core_out`, in, W: core result.
- `core_done`, in, 1: core completion.

## Operation
FSM states: IDLE, LOAD, RUN, RESP.

- **IDLE**
  - If any `req_valid` bit is set, the winner w is the first set bit at or after the round-robin pointer `ptr`, searching cyclically.
  - `req_ready[w]` is 1 combinationally in this cycle only. Transfer occurs on `req_valid[w] & req_ready[w]`.
  - On transfer, latch a, b and id = w.
  - If a ≥ P or b ≥ P (unsigned W-bit compare): set err=1, data=0, go to RESP.
  - Otherwise go to LOAD.
- **LOAD**
  - `core_a`/`core_b` show the latched operands; `core_rst` stays 1 for exactly one cycle.
  - Go to RUN; clear the timeout counter.
- **RUN**
  - `core_rst` = 0.
  - If `core_done` = 1: capture `core_out` into data, err=0, go to RESP.
  - Else if the counter reaches TIMEOUT−1: err=1, data=0, go to RESP.
  - Otherwise increment the counter.
- **RESP**
  - `resp_valid` = 1, with `resp_id`/`resp_data`/`resp_err` stable.
  - `core_rst` returns to 1.
  - On `resp_ready`: set `ptr` ← (id+1) mod N_REQ, go to IDLE.
- `core_done` is ignored outside RUN.
- `req_ready` is all-zero outside IDLE.
- `core_a`/`core_b` hold the last latched operands (0 after reset).
- The requester must hold `req_valid` and its operands stable until `req_ready`. A valid bit dropped before grant is simply not served.
- Operands equal to P are invalid; P−1 is valid.

## Timing
- Reset values:
  - FSM = IDLE, `ptr` = 0, counter = 0.
  - `req_ready` = 0 (combinational; 0 while `rst` is asserted).
  - `resp_valid` = 0, `resp_id` = 0, `resp_data` = 0, `resp_err` = 0.
  - `core_a` = 0, `core_b` = 0, `core_rst` = 1.
- Reset during any state aborts the operation immediately. The in-flight request is lost; the requester must re-issue.
- Normal path, with the accept edge as cycle 0:
  - LOAD in cycle 1.
  - RUN from cycle 2.
  - If `core_done` is first seen in RUN cycle k (k = 0…TIMEOUT−1), `resp_valid` rises at cycle 3+k.
- Range-error path: `resp_valid` at cycle 1; the core is never released.
- Timeout path: `resp_valid` at cycle 2+TIMEOUT.
- Minimum spacing between back-to-back accepts is 1 cycle after the `resp_ready` handshake. Response and new accept never occur in the same cycle.
- Throughput is one operation in flight.

## Structure
- Package `modadd_pkg`:
  - `W`, P constant.
  - `state_t` enum {IDLE, LOAD, RUN, RESP}.
  - Timeout counter width function.
- Sub-module `rr_arbiter`:
  - Parameterized N.
  - Inputs: `req` vector, `ptr`.
  - Outputs: one-hot `grant`, encoded index, `any`.
  - Purely combinational; `ptr` is owned by `modadd_sched`.
- Top level: FSM, operand/result registers, range comparators, timeout counter.

## Test plan
- **Single request:** after reset, req0 sends a=5, b=7 (real core) → `resp_id`=0, `resp_data`=12, `resp_err`=0. `core_rst` is high in LOAD and low only in RUN.
- **Wrap-around:** req2 sends a = b = P−1 (7fff…ffec) → `resp_data` = 7fff…ffeb, `resp_err`=0.
- **Fairness:**
  - All four `req_valid` high at reset release → service order 0,1,2,3.
  - Then hold req1 and req3 valid continuously → order alternates 1,3,1,3.
- **Range check:** req3 sends a = P (7fff…ffed), b=1 → `resp_err`=1, `resp_data`=0, `resp_valid` at cycle 1, `core_rst` never low.
- **Timeout:** core model never asserts `core_done` → `resp_err`=1 exactly TIMEOUT RUN cycles after LOAD; the next request is served normally.
- **Backpressure and reset:**
  - Hold `resp_ready` low for 10 cycles → response fields stable, no `req_ready` asserted.
  - Assert `rst` mid-RUN → all outputs take their reset values immediately, FSM returns to IDLE, `ptr`=0.
